// File: rtl/lynx_reset_pkg.sv
// Shared types for the core reset sequencer: FSM states, reset causes and
// the trigger-priority helper.
package lynx_reset_pkg;

   typedef enum logic [1:0] {
      PWRUP = 2'd0,
      RST   = 2'd1,
      RUN   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_POR  = 2'd0,
      CAUSE_REQ  = 2'd1,
      CAUSE_OPT  = 2'd2,
      CAUSE_HOLD = 2'd3
   } cause_e;

   // Highest-priority active trigger; an option change is the fallback.
   function automatic cause_e trig_cause(input logic hold, input logic req);
      cause_e c;
      if (hold) begin
         c = CAUSE_HOLD;
      end else if (req) begin
         c = CAUSE_REQ;
      end else begin
         c = CAUSE_OPT;
      end
      return c;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Sequencer control/status bundle: the master drives enables, options and
// requests; the sequencer (slave) returns power, core reset, run and cause.
interface reset_sequencer_if #(
   parameter int unsigned WATCH_BITS = 8
);

   logic                  ce;
   logic [WATCH_BITS-1:0] status_watch;
   logic [WATCH_BITS-1:0] watch_mask;
   logic                  req;
   logic                  hold;
   logic                  power;
   logic                  core_reset;
   logic                  run;
   logic [1:0]            cause;

   modport master (
      output ce, status_watch, watch_mask, req, hold,
      input  power, core_reset, run, cause
   );

   modport slave (
      input  ce, status_watch, watch_mask, req, hold,
      output power, core_reset, run, cause
   );

endinterface

// File: rtl/option_change_detect.sv
// Flags a change on any masked-in option bit relative to the value seen on
// the previous ce tick; history follows every bit regardless of the mask.
module option_change_detect #(
   parameter int unsigned WATCH_BITS = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ce,
   input  logic [WATCH_BITS-1:0] status_watch,
   input  logic [WATCH_BITS-1:0] watch_mask,
   output logic                  chg
);

   logic [WATCH_BITS-1:0] prev_q;
   logic [WATCH_BITS-1:0] prev_d;

   // Only the option bits move prev, so a mask edit alone never fires.
   always_comb begin
      prev_d = prev_q;
      chg    = 1'b0;
      if (ce) begin
         prev_d = status_watch;
         chg    = |((status_watch ^ prev_q) & watch_mask);
      end
   end

   // Reset loads the live value so release does not see a false edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q <= status_watch;
      end else begin
         prev_q <= prev_d;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Power-on and core-reset sequencer: power-up delay, then a core reset that
// is re-armed by hold, request or option changes and released after a quiet run.
module reset_sequencer
   import lynx_reset_pkg::*;
#(
   parameter int unsigned WATCH_BITS   = 8,
   parameter int unsigned POWER_CYCLES = 8,
   parameter int unsigned RESET_CYCLES = 16
) (
   input  logic              clock,
   input  logic              reset,
   reset_sequencer_if.slave  bus
);

   localparam int unsigned MAX_CYCLES = (POWER_CYCLES > RESET_CYCLES) ? POWER_CYCLES
                                                                      : RESET_CYCLES;
   localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] PWR_LAST = CW'(POWER_CYCLES - 1);
   localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);

   state_e        state_q,      state_d;
   logic [CW-1:0] cnt_q,        cnt_d;
   logic          power_q,      power_d;
   logic          core_reset_q, core_reset_d;
   logic          run_q,        run_d;
   cause_e        cause_q,      cause_d;

   logic chg;
   logic trig;

   option_change_detect #(
      .WATCH_BITS (WATCH_BITS)
   ) u_chg (
      .clock        (clock),
      .reset        (reset),
      .ce           (bus.ce),
      .status_watch (bus.status_watch),
      .watch_mask   (bus.watch_mask),
      .chg          (chg)
   );

   assign trig = bus.hold | bus.req | chg;

   // Next state; nothing moves on cycles without ce.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      power_d      = power_q;
      core_reset_d = core_reset_q;
      cause_d      = cause_q;

      if (bus.ce) begin
         case (state_q)
            PWRUP: begin
               if (cnt_q == PWR_LAST) begin
                  power_d = 1'b1;
                  cnt_d   = '0;
                  state_d = RST;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            RST: begin
               if (trig) begin
                  cnt_d   = '0;
                  cause_d = trig_cause(bus.hold, bus.req);
               end else if (cnt_q == RST_LAST) begin
                  core_reset_d = 1'b0;
                  state_d      = RUN;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            RUN: begin
               if (trig) begin
                  core_reset_d = 1'b1;
                  cnt_d        = '0;
                  cause_d      = trig_cause(bus.hold, bus.req);
                  state_d      = RST;
               end
            end
            default: begin
               state_d = PWRUP;
               cnt_d   = '0;
            end
         endcase
      end

      run_d = power_d & ~core_reset_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= PWRUP;
         cnt_q        <= '0;
         power_q      <= 1'b0;
         core_reset_q <= 1'b1;
         run_q        <= 1'b0;
         cause_q      <= CAUSE_POR;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         power_q      <= power_d;
         core_reset_q <= core_reset_d;
         run_q        <= run_d;
         cause_q      <= cause_d;
      end
   end

   assign bus.power      = power_q;
   assign bus.core_reset = core_reset_q;
   assign bus.run        = run_q;
   assign bus.cause      = cause_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised power-on and core-reset sequencer for the machine cores, clocked on the system clock and advanced only on the core clock-enable. Generalises the fixed power/reset counters of the Lynx top level. Adds configurable power-up and reset lengths, N masked option bits whose change restarts the machine, a level "hold" input (e.g. ioctl_download) that pins reset, and a reported reset cause.

Parameters:
- WATCH_BITS, 8, number of status/option bits monitored for change.
- POWER_CYCLES, 8, ce ticks from reset release to power high (>=1).
- RESET_CYCLES, 16, ce ticks core_reset stays high after last trigger (>=1).

Ports:
- clock  in  1  system clock (e.g. clock24)
- reset  in  1  synchronous active-high reset (e.g. ~pll_locked)
- ce  in  1  core clock-enable; all sequencing advances only when high
- status_watch  in  WATCH_BITS  option bits, already in clock domain
- watch_mask  in  WATCH_BITS  1 = bit change triggers core reset
- req  in  1  level reset request (OSD reset / button)
- hold  in  1  level hold-in-reset (download in progress)
- power  out  1  high once power-up delay elapsed
- core_reset  out  1  active-high reset to core
- run  out  1  power & ~core_reset
- cause  out  2  last reset cause: 0 POR, 1 REQ, 2 OPTION, 3 HOLD

Behaviour:
- Counter width CW = $clog2(max(POWER_CYCLES,RESET_CYCLES)+1).
- States: PWRUP, RST, RUN.
- reset=1 at any clock, any state:
  - state<=PWRUP, cnt<=0, power<=0, core_reset<=1, cause<=0.
  - prev<=status_watch, so no spurious change on release.
- ce=0: no state, counter, prev or output changes, except under reset.
- Option change detection:
  - chg = |((status_watch ^ prev) & watch_mask), evaluated on ce cycles only.
  - prev<=status_watch on every ce, regardless of mask.
  - A mask change alone never triggers.
- Trigger priority: hold > req > chg. trig = hold|req|chg.
- PWRUP, on ce:
  - cnt++.
  - When cnt==POWER_CYCLES-1: power<=1, cnt<=0, go to RST.
  - Triggers are ignored in PWRUP; prev still tracks.
- RST, on ce:
  - If trig: cnt<=0 and cause<=highest-priority trigger.
  - Else if cnt==RESET_CYCLES-1: core_reset<=0, go to RUN.
  - Else cnt++.
- RUN, on ce with trig:
  - core_reset<=1 on the same edge (1-clock latency from the sampling edge).
  - cnt<=0, cause updated, go to RST.
- Outputs are registered. run is a registered or direct AND of registered signals; no glitches.
- power never falls except on reset.
- hold held indefinitely: core_reset stays high; release completes RESET_CYCLES ce after the last ce with hold=1.
- Retrigger at cnt==RESET_CYCLES-1 restarts the full count.
- Exact-boundary case: release occurs when the last ce with trig=0 reaches RESET_CYCLES-1, i.e. RESET_CYCLES quiet ce ticks in RST.

Decomposition:
- Package lynx_reset_pkg: state enum (PWRUP, RST, RUN) and cause enum (CAUSE_POR=0, CAUSE_REQ=1, CAUSE_OPT=2, CAUSE_HOLD=3).
- Sub-module option_change_detect (WATCH_BITS): holds prev, outputs chg, inputs clock/reset/ce/status_watch/watch_mask.
- Top of the sequencer holds the FSM and counter.

Test Plan:
All scenarios use defaults with ce every 2nd clock.
1. POR: reset high 3 clocks, then low -> power rises after 8th ce (clock 16); core_reset falls after 16 further ce; run=1; cause=0.
2. In RUN, watch_mask=8'h02, toggle status_watch[1] -> core_reset=1 at first ce edge, cause=2, low after 16 quiet ce. Then toggle status_watch[0] (masked) -> no reset.
3. In RUN, hold=1 for 100 ce -> core_reset high throughout, cause=3; falls exactly 16 ce after hold drops.
4. Same ce: req=1 and masked-in bit toggles -> cause=1. Same ce: hold=1 and req=1 -> cause=3.
5. In RST at cnt=15, pulse req for one ce -> count restarts, core_reset high for 16 more quiet ce.
6. ce held 0 for 50 clocks mid-RST -> nothing changes. Then reset asserted mid-RST -> power=0, core_reset=1, cause=0 on the next clock; full sequence repeats.
